// File: rtl/core_bus_pkg.sv
// Shared definitions for the core/cache request bus: tag field encodings,
// the packed tag layout, the arbiter state set and the line length.
package core_bus_pkg;

  localparam int BEATS = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [3:0] KIND_MEMORY = 4'd1;
  localparam logic [3:0] KIND_MMIO   = 4'd2;
  localparam logic [3:0] KIND_PORT   = 4'd3;
  localparam logic [3:0] KIND_IRQ    = 4'd4;

  localparam logic SRC_INST = 1'b1;
  localparam logic SRC_DATA = 1'b0;

  typedef struct packed {
    logic       rw;
    logic [3:0] kind;
    logic       src;
    logic [6:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WDATA,
    ST_RESP
  } state_t;

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Client request/response ports plus the core-facing side of the cache bus.
// master = the arbiter, slave = the clients and cache around it.
interface core_bus_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic                  if_req_valid;
    logic [DATA_WIDTH-1:0] if_req_addr;
    logic                  if_req_ready;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_resp_data;
    logic                  if_resp_last;

    logic                  d_req_valid;
    logic                  d_req_write;
    logic [3:0]            d_req_kind;
    logic [DATA_WIDTH-1:0] d_req_addr;
    logic                  d_req_ready;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_wdata_ready;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;
    logic                  d_resp_last;

    logic [DATA_WIDTH-1:0] bus_req;
    logic [TAG_WIDTH-1:0]  bus_reqtag;
    logic                  bus_reqcyc;
    logic                  bus_reqack;
    logic [DATA_WIDTH-1:0] bus_resp;
    logic [TAG_WIDTH-1:0]  bus_resptag;
    logic                  bus_respcyc;
    logic                  bus_respack;

    logic                  err_stray;

    modport master (
        input  if_req_valid, if_req_addr, d_req_valid, d_req_write, d_req_kind,
               d_req_addr, d_wdata, bus_reqack, bus_resp, bus_resptag, bus_respcyc,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_last,
               d_req_ready, d_wdata_ready, d_resp_valid, d_resp_data, d_resp_last,
               bus_req, bus_reqtag, bus_reqcyc, bus_respack, err_stray
    );

    modport slave (
        output if_req_valid, if_req_addr, d_req_valid, d_req_write, d_req_kind,
               d_req_addr, d_wdata, bus_reqack, bus_resp, bus_resptag, bus_respcyc,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_last,
               d_req_ready, d_wdata_ready, d_resp_valid, d_resp_data, d_resp_last,
               bus_req, bus_reqtag, bus_reqcyc, bus_respack, err_stray
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// req[0]/gnt[0] is fetch, req[1]/gnt[1] is data; data counts as last after reset.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_q)) gnt[0] = 1'b1;
        else if (req[1])                   gnt[1] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 last_q <= 1'b1;
        else if (take && |gnt)     last_q <= gnt[1];
    end
endmodule

// File: rtl/core_bus_arbiter.sv
// Core-side bus master: grants fetch or data, issues one tagged transaction,
// streams write beats and routes tag-matched read beats back to the requester.
module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BEATS      = core_bus_pkg::BEATS
) (
    input logic                clk,
    input logic                reset,
    core_bus_arbiter_if.master bus
);
    localparam int              BW        = $clog2(BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q;
    tag_t                  tag_q;
    logic [6:0]            id_q;
    logic [BW-1:0]         beat_q;
    logic [1:0]            gnt;
    logic                  grant_take;
    logic                  beat_inc;
    logic                  resp_match;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.d_req_valid, bus.if_req_valid}),
        .take  (grant_take),
        .gnt   (gnt)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d           = state_q;
        grant_take        = 1'b0;
        beat_inc          = 1'b0;
        bus.if_req_ready  = 1'b0;
        bus.if_resp_valid = 1'b0;
        bus.if_resp_data  = '0;
        bus.if_resp_last  = 1'b0;
        bus.d_req_ready   = 1'b0;
        bus.d_wdata_ready = 1'b0;
        bus.d_resp_valid  = 1'b0;
        bus.d_resp_data   = '0;
        bus.d_resp_last   = 1'b0;
        bus.bus_req       = '0;
        bus.bus_reqtag    = '0;
        bus.bus_reqcyc    = 1'b0;
        resp_match        = (state_q == ST_RESP) && bus.bus_respcyc &&
                            (bus.bus_resptag == TAG_WIDTH'(tag_q));

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    grant_take = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = addr_q;
                bus.bus_reqtag = TAG_WIDTH'(tag_q);
                if (bus.bus_reqack) begin
                    if (tag_q.src == SRC_INST) bus.if_req_ready = 1'b1;
                    else                       bus.d_req_ready  = 1'b1;
                    state_d = (tag_q.rw == RW_WRITE) ? ST_WDATA : ST_RESP;
                end
            end
            ST_WDATA: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = bus.d_wdata;
                bus.bus_reqtag = TAG_WIDTH'(tag_q);
                if (bus.bus_reqack) begin
                    bus.d_wdata_ready = 1'b1;
                    beat_inc          = 1'b1;
                    if (beat_q == LAST_BEAT) state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (resp_match) begin
                    beat_inc = 1'b1;
                    if (tag_q.src == SRC_INST) begin
                        bus.if_resp_valid = 1'b1;
                        bus.if_resp_data  = bus.bus_resp;
                        bus.if_resp_last  = (beat_q == LAST_BEAT);
                    end else begin
                        bus.d_resp_valid = 1'b1;
                        bus.d_resp_data  = bus.bus_resp;
                        bus.d_resp_last  = (beat_q == LAST_BEAT);
                    end
                    if (beat_q == LAST_BEAT) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any response cycle is acked; only a tag match in RESP is a real beat.
        bus.bus_respack = bus.bus_respcyc && !reset;
        bus.err_stray   = bus.bus_respcyc && !resp_match && !reset;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the latched address/tag are reset too, so an aborted transaction leaves nothing behind.
            state_q <= ST_IDLE;
            addr_q  <= '0;
            tag_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_take) begin
                if (gnt[0]) begin
                    addr_q <= bus.if_req_addr;
                    tag_q  <= '{rw: RW_READ, kind: KIND_MEMORY, src: SRC_INST, id: id_q};
                end else begin
                    addr_q <= bus.d_req_addr;
                    tag_q  <= '{rw: !bus.d_req_write, kind: bus.d_req_kind, src: SRC_DATA, id: id_q};
                end
                id_q   <= id_q + 7'd1;
                beat_q <= '0;
            end else if (beat_inc) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench: random clients and cache around the arbiter, a
// transaction-level reference model checked every cycle, plus directed scenarios.
module tb_core_bus_arbiter;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;
    localparam logic [3:0] K_MEM  = 4'd1;
    localparam logic [3:0] K_MMIO = 4'd2;
    localparam logic [3:0] K_PORT = 4'd3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_bus_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
    core_bus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BEATS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic outs_any();
        return |{bus.bus_reqcyc, bus.bus_req, bus.bus_reqtag, bus.bus_respack,
                 bus.if_req_ready, bus.if_resp_valid, bus.if_resp_data, bus.if_resp_last,
                 bus.d_req_ready, bus.d_wdata_ready, bus.d_resp_valid, bus.d_resp_data,
                 bus.d_resp_last, bus.err_stray};
    endfunction

    // Stimulus configuration, written only by the main sequence.
    int fetch_goal = 0, data_goal = 0;
    int fetch_rate = 100, data_rate = 100;
    int write_mode = 0;              // 0 read, 1 write, 2 random
    bit fix_addr = 1'b0, fix_seed = 1'b0, force_stray = 1'b0;
    logic [63:0] fetch_addr_fix = '0, data_addr_fix = '0;
    int ack_pct = 100, resp_pct = 100, stray_pct = 0, idle_stray_pct = 0;

    // Fetch client: holds valid until it sees the ready pulse.
    int fetch_issued = 0;
    initial begin
        logic rdy;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = '0;
        forever begin
            @(negedge clk); rdy = bus.if_req_ready;
            @(posedge clk); #1;
            if (reset) bus.if_req_valid = 1'b0;
            else if (bus.if_req_valid) begin
                if (rdy) bus.if_req_valid = 1'b0;
            end else if (fetch_issued < fetch_goal && $urandom_range(0, 99) < fetch_rate) begin
                bus.if_req_valid = 1'b1;
                bus.if_req_addr  = fix_addr ? fetch_addr_fix : ({$urandom, $urandom} & ~64'h3f);
                fetch_issued++;
            end
        end
    end

    // Data client: requests plus a write-beat source advanced on each d_wdata_ready.
    int data_issued = 0;
    initial begin
        logic rdy, wr;
        logic [31:0] wseed;
        int wbeat;
        wseed = '0; wbeat = 0;
        bus.d_req_valid = 1'b0; bus.d_req_write = 1'b0; bus.d_req_kind = K_MEM;
        bus.d_req_addr  = '0;   bus.d_wdata     = '0;
        forever begin
            @(negedge clk); rdy = bus.d_req_ready; wr = bus.d_wdata_ready;
            @(posedge clk); #1;
            if (reset) begin
                bus.d_req_valid = 1'b0;
                wbeat = 0;
            end else begin
                if (wr) wbeat++;
                if (bus.d_req_valid) begin
                    if (rdy) bus.d_req_valid = 1'b0;
                end else if (data_issued < data_goal && $urandom_range(0, 99) < data_rate) begin
                    bus.d_req_valid = 1'b1;
                    bus.d_req_write = (write_mode == 2) ? 1'($urandom_range(0, 1)) : (write_mode == 1);
                    case ($urandom_range(0, 2))
                        0:       bus.d_req_kind = K_MEM;
                        1:       bus.d_req_kind = K_MMIO;
                        default: bus.d_req_kind = K_PORT;
                    endcase
                    bus.d_req_addr = fix_addr ? data_addr_fix : ({$urandom, $urandom} & ~64'h3f);
                    wseed = fix_seed ? 32'd0 : $urandom;
                    wbeat = 0;
                    data_issued++;
                end
            end
            bus.d_wdata = {wseed, 32'(wbeat)};
        end
    end

    // Cache: random acks, returns BEATS beats per accepted read, optional stray beats.
    int cache_left = 0;
    initial begin
        logic cyc_ack;
        logic [TW-1:0] seen_tag, cur_tag;
        bit forced_sent;
        cur_tag = '0; forced_sent = 1'b0;
        bus.bus_reqack = 1'b0; bus.bus_respcyc = 1'b0;
        bus.bus_resp   = '0;   bus.bus_resptag = '0;
        forever begin
            @(negedge clk);
            cyc_ack  = bus.bus_reqcyc && bus.bus_reqack;
            seen_tag = bus.bus_reqtag;
            @(posedge clk); #1;
            bus.bus_respcyc = 1'b0;
            if (reset) begin
                cache_left = 0;
                bus.bus_reqack = 1'b0;
            end else begin
                if (cyc_ack && seen_tag[12]) begin
                    cache_left  = NB;
                    cur_tag     = seen_tag;
                    forced_sent = 1'b0;
                end
                bus.bus_reqack = ($urandom_range(0, 99) < ack_pct);
                bus.bus_resp   = {$urandom, $urandom};
                if (cache_left > 0 && $urandom_range(0, 99) < resp_pct) begin
                    bus.bus_respcyc = 1'b1;
                    if ((force_stray && !forced_sent && cache_left == NB - 4) ||
                        $urandom_range(0, 99) < stray_pct) begin
                        bus.bus_resptag = cur_tag ^ TW'($urandom_range(1, 127));
                        forced_sent = 1'b1;
                    end else begin
                        bus.bus_resptag = cur_tag;
                        cache_left--;
                    end
                end else if (cache_left == 0 && $urandom_range(0, 99) < idle_stray_pct) begin
                    bus.bus_respcyc = 1'b1;
                    bus.bus_resptag = TW'($urandom);
                end
            end
        end
    end

    // Reference model: one outstanding transaction described by counters, checked every cycle.
    bit last_data = 1'b1;
    int id_next = 0;
    bit req_pending = 0, wr_active = 0, rd_active = 0, model_busy = 0;
    int wcount = 0, rcount = 0;
    bit cur_src = 0, cur_write = 0;
    logic [63:0] cur_addr = '0;
    logic [TW-1:0] cur_tag = '0;
    logic [TW-1:0] tag_log[$];
    logic [63:0] addr_log[$], wlog[$];
    int n_ifv = 0, n_ifl = 0, n_ifrdy = 0, n_wrdy = 0, n_err = 0;

    initial forever begin
        logic ack, rc, match, busy, pick_fetch;
        logic [9:0] exp_ctl;
        @(negedge clk);
        if (reset) begin
            check("reset_outputs", outs_any(), 0);
            last_data = 1'b1; id_next = 0;
            req_pending = 0; wr_active = 0; rd_active = 0; model_busy = 0;
        end else begin
            ack   = bus.bus_reqack;
            rc    = bus.bus_respcyc;
            match = rd_active && rc && (bus.bus_resptag == cur_tag);
            exp_ctl = {req_pending || wr_active,
                       req_pending && ack && cur_src, req_pending && ack && !cur_src,
                       wr_active && ack, rc, rc && !match,
                       match && cur_src, match && cur_src && rcount == NB - 1,
                       match && !cur_src, match && !cur_src && rcount == NB - 1};
            check("ctl", {bus.bus_reqcyc, bus.if_req_ready, bus.d_req_ready, bus.d_wdata_ready,
                          bus.bus_respack, bus.err_stray, bus.if_resp_valid, bus.if_resp_last,
                          bus.d_resp_valid, bus.d_resp_last}, exp_ctl);
            if (req_pending || wr_active)
                check("bus_req", bus.bus_req, req_pending ? cur_addr : bus.d_wdata);
            if (req_pending) check("bus_reqtag", bus.bus_reqtag, cur_tag);
            if (match) check("resp_data", cur_src ? bus.if_resp_data : bus.d_resp_data, bus.bus_resp);

            if (bus.bus_reqcyc && ack && req_pending) begin
                tag_log.push_back(bus.bus_reqtag);
                addr_log.push_back(bus.bus_req);
            end
            if (bus.d_wdata_ready) wlog.push_back(bus.bus_req);
            n_ifv   += int'(bus.if_resp_valid);
            n_ifl   += int'(bus.if_resp_last);
            n_ifrdy += int'(bus.if_req_ready);
            n_wrdy  += int'(bus.d_wdata_ready);
            n_err   += int'(bus.err_stray);

            busy = req_pending || wr_active || rd_active;
            if (req_pending && ack) begin
                req_pending = 0;
                if (cur_write) begin wr_active = 1; wcount = 0; end
                else           begin rd_active = 1; rcount = 0; end
            end else if (wr_active && ack) begin
                wcount++;
                if (wcount == NB) wr_active = 0;
            end
            if (match) begin
                rcount++;
                if (rcount == NB) rd_active = 0;
            end
            if (!busy && (bus.if_req_valid || bus.d_req_valid)) begin
                pick_fetch = bus.if_req_valid && (!bus.d_req_valid || last_data);
                last_data  = !pick_fetch;
                cur_src    = pick_fetch;
                cur_write  = pick_fetch ? 1'b0 : bus.d_req_write;
                cur_addr   = pick_fetch ? bus.if_req_addr : bus.d_req_addr;
                cur_tag    = pick_fetch ? {1'b1, K_MEM, 1'b1, 7'(id_next)}
                                        : {!bus.d_req_write, bus.d_req_kind, 1'b0, 7'(id_next)};
                id_next    = (id_next + 1) % 128;
                req_pending = 1;
            end
            model_busy = req_pending || wr_active || rd_active;
        end
    end

    task automatic wait_done(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk); #1;
            done = fetch_issued == fetch_goal && data_issued == data_goal &&
                   !bus.if_req_valid && !bus.d_req_valid && !model_busy && cache_left == 0;
        end
        check("drain_in_time", done, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int b, nv, nl, nr, nw, wb, ne;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Fetch read of 0x1000 from reset: tag {1,0001,1,0}, 8 beats, one ready pulse.
        ack_pct = 40; fix_addr = 1'b1; fetch_addr_fix = 64'h1000;
        b = tag_log.size(); nv = n_ifv; nl = n_ifl; nr = n_ifrdy;
        @(negedge clk) fetch_goal += 1;
        wait_done(500);
        check("fetch_tag", tag_log[b], 13'h1180);
        check("fetch_addr", addr_log[b], 64'h1000);
        check("fetch_beats", n_ifv - nv, 8);
        check("fetch_last", n_ifl - nl, 1);
        check("fetch_ready", n_ifrdy - nr, 1);

        // Both clients valid straight out of reset: fetch, data, fetch.
        pulse_reset();
        fix_addr = 1'b0; write_mode = 0; ack_pct = 70;
        b = tag_log.size();
        @(negedge clk) begin fetch_goal += 2; data_goal += 1; end
        wait_done(1000);
        check("rr_first_src", tag_log[b][7], 1);
        check("rr_second_src", tag_log[b + 1][7], 0);
        check("rr_third_src", tag_log[b + 2][7], 1);
        check("rr_second_id", tag_log[b + 1][6:0], 1);

        // Write of 0x2000 with words 0..7 and gappy acks.
        write_mode = 1; fix_addr = 1'b1; data_addr_fix = 64'h2000; fix_seed = 1'b1; ack_pct = 50;
        b = tag_log.size(); wb = wlog.size(); nw = n_wrdy;
        @(negedge clk) data_goal += 1;
        wait_done(1000);
        check("wr_addr", addr_log[b], 64'h2000);
        check("wr_rw_bit", tag_log[b][12], 0);
        check("wr_beats", n_wrdy - nw, 8);
        for (int i = 0; i < 8; i++) check("wr_word", wlog[wb + i], 64'(i));

        // Stray beat in the middle of a read.
        fix_addr = 1'b0; fix_seed = 1'b0; ack_pct = 100; resp_pct = 80; force_stray = 1'b1;
        nv = n_ifv; nl = n_ifl; ne = n_err;
        @(negedge clk) fetch_goal += 1;
        wait_done(1000);
        force_stray = 1'b0; resp_pct = 100;
        check("stray_beats", n_ifv - nv, 8);
        check("stray_last", n_ifl - nl, 1);
        check("stray_flagged", (n_err - ne) >= 1, 1);

        // Asynchronous reset at beat 4 of a read, then the next grant restarts at id 0.
        @(negedge clk) fetch_goal += 1;
        for (int i = 0; i < 200 && !(rd_active && rcount == 4); i++) begin
            @(negedge clk); #1;
        end
        check("reached_beat4", rd_active && rcount == 4, 1);
        @(posedge clk); #3 reset = 1'b1;
        #1 check("reset_async", outs_any(), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        b = tag_log.size();
        @(negedge clk) fetch_goal += 1;
        wait_done(500);
        check("post_reset_tag", tag_log[b], 13'h1180);

        // 130 back-to-back fetches: id wraps 127 -> 0.
        pulse_reset();
        b = tag_log.size();
        @(negedge clk) fetch_goal += 130;
        wait_done(6000);
        check("wrap_id127", tag_log[b + 127][6:0], 127);
        check("wrap_id0", tag_log[b + 128], 13'h1180);
        check("wrap_id1", tag_log[b + 129][6:0], 1);

        // Random mix of reads and writes from both clients.
        write_mode = 2; fetch_rate = 60; data_rate = 60;
        ack_pct = 60; resp_pct = 70; stray_pct = 15; idle_stray_pct = 5;
        b = tag_log.size();
        @(negedge clk) begin fetch_goal += 60; data_goal += 60; end
        wait_done(20000);
        check("random_txns", tag_log.size() - b, 120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Core-side master for the core/cache request bus. Arbitrates between the instruction-fetch unit and the data memory unit, issues one tagged transaction at a time on the bus, and streams write data out. It routes the 8-beat read response back to the requesting client by tag. It sits directly upstream of the cache, driving the core-facing side of `CoreCacheBus`.

## Interface
- `DATA_WIDTH`, 64, width of bus request/response words and addresses.
- `TAG_WIDTH`, 13, bus tag width; tag layout is {rw[12], kind[11:8], src[7], id[6:0]}.
- `BEATS`, 8, beats per line transfer (power of two).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `if_req_valid` in 1: fetch line-read request; held until `if_req_ready`.
- `if_req_addr` in DATA_WIDTH: fetch line address.
- `if_req_ready` out 1: one-cycle accept pulse.
- `if_resp_valid` out 1, `if_resp_data` out DATA_WIDTH, `if_resp_last` out 1: response beats; no backpressure.
- `d_req_valid` in 1, `d_req_write` in 1, `d_req_kind` in 4, `d_req_addr` in DATA_WIDTH: data request (kind MEMORY/MMIO/PORT).
- `d_req_ready` out 1: accept pulse.
- `d_wdata` in DATA_WIDTH: current write beat; must be valid whenever `d_wdata_ready` can pulse.
- `d_wdata_ready` out 1: write beat consumed.
- `d_resp_valid` out 1, `d_resp_data` out DATA_WIDTH, `d_resp_last` out 1: data read beats.
- `bus_req` out DATA_WIDTH, `bus_reqtag` out TAG_WIDTH, `bus_reqcyc` out 1, `bus_reqack` in 1.
- `bus_resp` in DATA_WIDTH, `bus_resptag` in TAG_WIDTH, `bus_respcyc` in 1, `bus_respack` out 1.
- `err_stray` out 1: pulse on a response whose tag does not match the outstanding transaction.

## Operation
- FSM states: IDLE, REQ, WDATA, RESP.
- IDLE: if any client is valid, grant by round-robin. On a tie, grant the client not granted last; the first grant after reset goes to fetch. Latch addr/tag, then go to REQ.
  - Fetch tag: rw=READ(1), kind=MEMORY, src=INST(1).
  - Data tag: rw=!d_req_write, kind=d_req_kind, src=DATA(0).
  - `id` is a 7-bit counter incremented per grant, wrapping 127->0.
- REQ: drive `bus_reqcyc`=1, `bus_req`=addr, `bus_reqtag`=tag. On `bus_reqack`, pulse the granted client's `*_req_ready` in that same cycle. Then go to WDATA for a write, otherwise RESP.
- WDATA: drive `bus_reqcyc`=1 and `bus_req`=`d_wdata`. Each cycle with `bus_reqack` counts one beat and pulses `d_wdata_ready`. After beat BEATS-1, go to IDLE. Writes get no response.
- RESP: when `bus_respcyc` is high, assert `bus_respack` combinationally in the same cycle. A response matches only if `bus_resptag` equals the latched tag.
  - Match: forward `bus_resp` to the src client's resp port and increment the beat counter. Assert `*_resp_last` on beat BEATS-1, then go to IDLE.
  - Mismatch: still ack, drop the beat, pulse `err_stray`, counter unchanged.
- Exactly one transaction is outstanding at a time. Client requests arriving outside IDLE wait.
- Beat counter is log2(BEATS) bits and clears on every grant.

## Timing
- Reset values: all outputs 0 (`bus_reqcyc`, `bus_respack`, all valids/readies/pulses), FSM IDLE, id 0, last-grant = data (so fetch wins first).
- Reset mid-transaction aborts immediately. No draining; the cache side is reset concurrently.
- Grant to `bus_reqcyc`: 1 cycle (registered request fields).
- `bus_reqcyc` drops in the cycle after the final `bus_reqack`. In WDATA it stays high continuously between beats.
- Response path is combinational: `bus_respcyc` → `*_resp_valid`/`bus_respack`, zero latency.
- `bus_respcyc` outside RESP: ack and flag `err_stray`.
- Minimum read: 1 (grant) + 1 (ack) + BEATS cycles. Next grant can occur the cycle after the last beat.

## Structure
- Shared package `core_bus_pkg`: tag field constants (READ/WRITE, MEMORY/MMIO/PORT/IRQ, INST/DATA), a tag struct typedef, a state enum, and BEATS.
- One natural sub-module: `rr_arbiter2` (2-way round-robin with last-grant register).

## Test plan
- Fetch read addr 0x1000, cache acks after 2 cycles, returns 8 beats tag {1,0001,1,id0} → `if_resp_valid` ×8, `if_resp_last` on beat 8, `if_req_ready` pulse on the ack cycle.
- Simultaneous fetch and data valid out of reset → fetch granted first, data second, then fetch again if both are still valid.
- Data write 0x2000, data words 0..7, reqack with gaps → `bus_req` sequence addr,0..7, exactly 8 `d_wdata_ready` pulses, no response wait.
- Stray response (wrong id) mid-read → `bus_respack`=1, `err_stray` pulse, client sees no beat, count resumes correctly.
- Reset asserted at beat 4 of a read → all outputs 0 asynchronously. After release, next grant uses id 0.
- 130 back-to-back fetches → id wraps 127→0 and tags stay consistent.
